// File: rtl/debounce_multi.sv
// Multi-channel switch/button debouncer: 2-flop synchroniser per channel, shared
// sample tick, per-channel stability counter with one-clock rise/fall strobes.
module debounce_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TICK_DIV     = 1_000_000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] d_in,
  output logic [CHANNELS-1:0] q_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  localparam logic [TW-1:0] TC_LAST  = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TC_PRE   = TW'(TICK_DIV - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [TW-1:0]       r_tick_cnt;
  logic                r_tick;
  logic [CHANNELS-1:0] r_q;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CW-1:0]       r_cnt [CHANNELS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {CHANNELS{INIT_LEVEL}};
      r_sync2 <= {CHANNELS{INIT_LEVEL}};
    end else begin
      r_sync1 <= d_in;
      r_sync2 <= r_sync1;
    end
  end

  // tick is registered one count early so it is high exactly while the counter sits at TICK_DIV-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      if (r_tick_cnt == TC_LAST) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
      end
      r_tick <= (r_tick_cnt == TC_PRE);
    end
  end

  // A single clock of agreement between synchronised input and output aborts a pending change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q    <= {CHANNELS{INIT_LEVEL}};
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (r_sync2[i] == r_q[i]) begin
          r_cnt[i] <= '0;
        end else if (r_tick) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_q[i]    <= r_sync2[i];
            r_cnt[i]  <= '0;
            r_rise[i] <= r_sync2[i];
            r_fall[i] <= ~r_sync2[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign q_out = r_q;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign tick  = r_tick;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (4 channels, TICK_DIV=4, STABLE_TICKS=3):
// stimulus queues expected strobe events, a monitor pops and checks them.
module tb_debounce_multi;

  localparam int CH = 4;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] d_in;
  logic [CH-1:0] q_out;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          tick;

  typedef struct {
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] q;
    int            lo;
    int            hi;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  debounce_multi #(
    .CHANNELS    (CH),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .INIT_LEVEL  (1'b0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .d_in   (d_in),
    .q_out  (q_out),
    .rise   (rise),
    .fall   (fall),
    .tick   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    failures++;
    $display("FAIL %s %s (cycle %0d)", name, msg, cyc);
  endtask

  // Clean step: the strobe lands 11..14 posedges after the clock on which d_in changed.
  task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] r,
                       input logic [CH-1:0] f, input logic [CH-1:0] q);
    exp_t e;
    @(negedge clk);
    d_in = v;
    e.rise = r;
    e.fall = f;
    e.q    = q;
    e.lo   = cyc + 11;
    e.hi   = cyc + 14;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("drain_timeout", $sformatf("actual=%0d pending required=0", sb.size()));
      sb.delete();
    end
    repeat (20) @(posedge clk);
  endtask

  // Monitor: pops an expectation whenever the DUT strobes, and checks edge/strobe consistency.
  initial begin
    logic [CH-1:0] q_prev;
    exp_t          e;
    q_prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        q_prev = q_out;
      end else begin
        chk("strobe_exclusive", 32'(rise & fall), 32'(0));
        chk("strobe_vs_q_edge", 32'({rise, fall}), 32'({q_out & ~q_prev, ~q_out & q_prev}));
        if ((rise | fall) != '0) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_strobe", $sformatf("actual rise=%b fall=%b required none", rise, fall));
          end else begin
            e = sb.pop_front();
            chk("strobe_rise", 32'(rise), 32'(e.rise));
            chk("strobe_fall", 32'(fall), 32'(e.fall));
            chk("strobe_q", 32'(q_out), 32'(e.q));
            checks++;
            if (cyc < e.lo || cyc > e.hi) begin
              failures++;
              $display("FAIL strobe_cycle actual=%0d required=%0d..%0d", cyc, e.lo, e.hi);
            end
          end
        end
        q_prev = q_out;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int k;
    d_in    = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", 32'(q_out), 32'(0));
    chk("reset_rise", 32'(rise), 32'(0));
    chk("reset_fall", 32'(fall), 32'(0));
    chk("reset_tick", 32'(tick), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // 1: idle, tick every 4 clocks, first one on the 3rd posedge after release
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      #1;
      chk("t1_tick", 32'(tick), 32'((i % 4) == 3));
      chk("t1_idle", 32'({q_out, rise, fall}), 32'(0));
    end

    // 2: clean step on channel 0
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    drain(40);

    // 3: channel 1 bounces every 3 clocks, then settles high
    for (int i = 0; i < 14; i++) begin
      repeat (3) @(negedge clk);
      d_in[1] = ~d_in[1];
    end
    repeat (3) @(negedge clk);
    chk("t3_no_change_while_bouncing", 32'(q_out), 32'(4'b0001));
    drive(4'b0011, 4'b0010, 4'b0000, 4'b0011);
    drain(40);

    // 4: channel 2 high, then a 6-clock glitch low that must be rejected
    drive(4'b0111, 4'b0100, 4'b0000, 4'b0111);
    drain(40);
    @(negedge clk);
    d_in[2] = 1'b0;
    repeat (6) @(negedge clk);
    d_in[2] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t4_glitch_rejected", 32'(q_out), 32'(4'b0111));

    // 5: simultaneous multi-channel edges
    drive(4'b0000, 4'b0000, 4'b0111, 4'b0000);
    drain(40);
    drive(4'b1111, 4'b1111, 4'b0000, 4'b1111);
    drain(40);
    drive(4'b0101, 4'b0000, 4'b1010, 4'b0101);
    drain(40);
    drive(4'b0000, 4'b0000, 4'b0101, 4'b0000);
    drain(40);

    // 6: reset while channel 0 has two qualifying ticks pending
    @(negedge clk);
    d_in = 4'b0001;
    k = cyc;
    while (cyc < k + 10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_reset_q", 32'(q_out), 32'(0));
    chk("t6_reset_strobes", 32'({rise, fall, tick}), 32'(0));
    repeat (3) @(negedge clk);
    d_in    = 4'b0000;
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk("t6_tick_restart", 32'(tick), 32'(i == 3));
      chk("t6_after_release", 32'({q_out, rise, fall}), 32'(0));
    end
    repeat (30) @(posedge clk);
    #1;
    chk("t6_final_q", 32'(q_out), 32'(0));
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
